// File: rtl/alu_share_arb_pkg.sv
// Shared riscv_types package: ALU operation encoding plus the types used by
// the alu_share_arb response register.
package riscv_types;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_t;

  localparam int ALU_ARB_MAX_REQ = 4;

  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/alu_share_arb_if.sv
// Request/response bundle between NREQ requesters (master) and the shared
// ALU arbiter (slave); results come back on one shared bus.
interface alu_share_arb_if #(
  parameter int NREQ = 2
) ();
  import riscv_types::*;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  alu_t [NREQ-1:0]        req_ctrl;
  logic [NREQ-1:0][31:0]  req_op1;
  logic [NREQ-1:0][31:0]  req_op2;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ-1:0]        rsp_ready;
  logic [31:0]            rsp_result;
  logic                   rsp_zero;

  modport master (
    output req_valid, req_ctrl, req_op1, req_op2, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero
  );

  modport slave (
    input  req_valid, req_ctrl, req_op1, req_op2, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_share_arb_alu.sv
// Core combinational RV32 integer ALU; shifts use op2[4:0], SLT is signed,
// SLTU unsigned. Undefined encodings yield zero.
module alu
  import riscv_types::*;
(
  input  alu_t        i_ctrl,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  output logic [31:0] o_result,
  output logic        o_zero
);
  logic signed [31:0] w_s1;
  logic signed [31:0] w_s2;
  logic        [4:0]  w_sh;

  assign w_s1 = signed'(i_op1);
  assign w_s2 = signed'(i_op2);
  assign w_sh = i_op2[4:0];

  always_comb begin
    o_result = '0;
    case (i_ctrl)
      ALU_ADD:  o_result = i_op1 + i_op2;
      ALU_SUB:  o_result = i_op1 - i_op2;
      ALU_SLL:  o_result = i_op1 << w_sh;
      ALU_SLT:  o_result = {31'd0, (w_s1 < w_s2)};
      ALU_SLTU: o_result = {31'd0, (i_op1 < i_op2)};
      ALU_XOR:  o_result = i_op1 ^ i_op2;
      ALU_SRL:  o_result = i_op1 >> w_sh;
      ALU_SRA:  o_result = unsigned'(w_s1 >>> w_sh);
      ALU_OR:   o_result = i_op1 | i_op2;
      ALU_AND:  o_result = i_op1 & i_op2;
      default:  o_result = '0;
    endcase
    o_zero = (o_result == 32'd0);
  end
endmodule

// File: rtl/alu_share_arb.sv
// Shares one alu among NREQ requesters with a one-entry response register.
// Define ALU_ARB_RR_EN for round-robin grants; otherwise lowest index wins.
module alu_share_arb
  import riscv_types::*;
#(
  parameter int NREQ = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_share_arb_if.slave bus
);
  localparam int MAXR = ALU_ARB_MAX_REQ;
  typedef logic [1:0] idx_t;

  arb_state_t r_state, w_state_nxt;
  idx_t        r_own;
  logic [31:0] r_result;
  logic        r_zero;

  logic [MAXR-1:0]       w_vld;
  logic [MAXR-1:0]       w_rsp_rdy;
  alu_t [MAXR-1:0]       w_ctrl;
  logic [MAXR-1:0][31:0] w_op1;
  logic [MAXR-1:0][31:0] w_op2;
  idx_t        w_gnt;
  logic        w_gnt_vld;
  logic        w_drain;
  logic        w_can_accept;
  logic        w_accept;
  logic [31:0] w_alu_result;
  logic        w_alu_zero;

  // Pad per-requester inputs to the maximum width so 2-bit indices are always legal.
  always_comb begin
    w_vld     = '0;
    w_rsp_rdy = '0;
    w_op1     = '0;
    w_op2     = '0;
    for (int i = 0; i < MAXR; i++) w_ctrl[i] = ALU_ADD;
    for (int i = 0; i < NREQ; i++) begin
      w_vld[i]     = bus.req_valid[i];
      w_rsp_rdy[i] = bus.rsp_ready[i];
      w_ctrl[i]    = bus.req_ctrl[i];
      w_op1[i]     = bus.req_op1[i];
      w_op2[i]     = bus.req_op2[i];
    end
  end

`ifdef ALU_ARB_RR_EN
  idx_t r_ptr;

  always_comb begin
    idx_t v_idx;
    v_idx     = '0;
    w_gnt     = '0;
    w_gnt_vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      v_idx = idx_t'((int'(r_ptr) + k) % NREQ);
      if (!w_gnt_vld && w_vld[v_idx]) begin
        w_gnt     = v_idx;
        w_gnt_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ptr <= '0;
    else if (w_accept) r_ptr <= (int'(w_gnt) == NREQ - 1) ? '0 : w_gnt + idx_t'(1);
  end
`else
  always_comb begin
    w_gnt     = '0;
    w_gnt_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_vld[k]) begin
        w_gnt     = idx_t'(k);
        w_gnt_vld = 1'b1;
      end
    end
  end
`endif

  assign w_drain      = (r_state == ARB_FULL) && w_rsp_rdy[r_own];
  assign w_can_accept = (r_state == ARB_EMPTY) || w_drain;
  assign w_accept     = rst_n && w_can_accept && w_gnt_vld;

  alu u_alu (
    .i_ctrl   (w_ctrl[w_gnt]),
    .i_op1    (w_op1[w_gnt]),
    .i_op2    (w_op2[w_gnt]),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept)     w_state_nxt = ARB_FULL;
    else if (w_drain) w_state_nxt = ARB_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ARB_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // A drain alone leaves the held contents untouched; only an accept overwrites.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_own    <= '0;
    end else if (w_accept) begin
      r_result <= w_alu_result;
      r_zero   <= w_alu_zero;
      r_own    <= w_gnt;
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ready[i] = w_accept && (int'(w_gnt) == i);
      bus.rsp_valid[i] = (r_state == ARB_FULL) && (int'(r_own) == i);
    end
  end

  assign bus.rsp_result = r_result;
  assign bus.rsp_zero   = r_zero;
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed and randomized bench for alu_share_arb (NREQ=4) checked against a
// transaction-level model; honours ALU_ARB_RR_EN the same way as the design.
module tb_alu_share_arb;
  import riscv_types::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_share_arb_if #(.NREQ(N)) bus ();

  alu_share_arb #(.NREQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Model of the response register and arbitration pointer.
  bit          m_full;
  int          m_own;
  int          m_ptr;
  logic [31:0] m_res;
  logic        m_zero;
  logic [3:0]  last_ready;

  alu_t        ac[5] = '{ALU_SRA, ALU_SLL, ALU_SLTU, ALU_SLT, ALU_ADD};
  logic [31:0] aa[5] = '{32'h8000_0000, 32'h1, 32'h1, 32'h1, 32'hFFFF_FFFF};
  logic [31:0] ab[5] = '{32'h4, 32'h21, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1};
  logic [31:0] ae[5] = '{32'hF800_0000, 32'h2, 32'h1, 32'h0, 32'h0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(alu_t c, logic [31:0] a, logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (c)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return $unsigned($signed(a) >>> sh);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic int ref_grant(logic [3:0] v, int ptr);
`ifdef ALU_ARB_RR_EN
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
`else
    for (int k = 0; k < N; k++) if (v[k]) return k;
`endif
    return -1;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_op(input int i, input alu_t c, input logic [31:0] a, input logic [31:0] b);
    bus.req_ctrl[i] = c;
    bus.req_op1[i]  = a;
    bus.req_op2[i]  = b;
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_own  = 0;
    m_ptr  = 0;
    m_res  = 32'd0;
    m_zero = 1'b0;
  endtask

  // One clock: drive at negedge, check grant, update model at posedge, check response.
  task automatic step(input logic [3:0] v, input logic [3:0] rr);
    int          g;
    logic        can;
    logic [3:0]  er;
    logic [31:0] r;
    bus.req_valid = v;
    bus.rsp_ready = rr;
    #1;
    g   = ref_grant(v, m_ptr);
    can = !m_full || rr[m_own];
    er  = (can && g >= 0) ? 4'(1 << g) : 4'b0000;
    r   = (g >= 0) ? ref_alu(bus.req_ctrl[g], bus.req_op1[g], bus.req_op2[g]) : 32'd0;
    last_ready = bus.req_ready;
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    @(posedge clk);
    if (er != 4'b0000) begin
      m_full = 1'b1;
      m_own  = g;
      m_res  = r;
      m_zero = (r == 32'd0);
      m_ptr  = (g + 1) % N;
    end else if (m_full && rr[m_own]) begin
      m_full = 1'b0;
    end
    #1;
    chk("rsp_valid", 32'(bus.rsp_valid), m_full ? 32'(1 << m_own) : 32'd0);
    chk("rsp_result", bus.rsp_result, m_res);
    chk("rsp_zero", 32'(bus.rsp_zero), 32'(m_zero));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp_g;
    rst_n         = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    for (int i = 0; i < N; i++) set_op(i, ALU_ADD, 32'd0, 32'd0);
    #2;
    rst_n = 1'b0;
    model_reset();
    bus.req_valid = 4'b1111;
    @(negedge clk);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_result", bus.rsp_result, 32'd0);
    chk("reset_zero", 32'(bus.rsp_zero), 32'd0);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b1;

    // Single op: ADD 5+7 held for req0.
    set_op(0, ALU_ADD, 32'd5, 32'd7);
    step(4'b0001, 4'b0000);
    chk("single_valid", 32'(bus.rsp_valid), 32'h1);
    chk("single_result", bus.rsp_result, 32'd12);
    chk("single_zero", 32'(bus.rsp_zero), 32'd0);

    // Asynchronous reset while holding the result.
    bus.req_valid = 4'b0001;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_result", bus.rsp_result, 32'd0);
    chk("midrst_zero", 32'(bus.rsp_zero), 32'd0);
    chk("midrst_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0001, 4'b0000);
    chk("release_ready", 32'(last_ready), 32'h1);

    // Grant req3 so the round-robin pointer wraps to 0.
    set_op(3, ALU_ADD, 32'd1, 32'd2);
    step(4'b1000, 4'b1111);

    // Contention between req0 and req1 with no back-pressure.
    set_op(0, ALU_ADD, 32'd10, 32'd20);
    set_op(1, ALU_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    for (int k = 0; k < 4; k++) begin
      step(4'b0011, 4'b1111);
`ifdef ALU_ARB_RR_EN
      exp_g = (k % 2 == 0) ? 4'b0001 : 4'b0010;
`else
      exp_g = 4'b0001;
`endif
      chk("contention_grant", 32'(last_ready), 32'(exp_g));
    end

    // Back-pressure from req1, then same-cycle drain and accept of req0.
    set_op(1, ALU_SUB, 32'd9, 32'd9);
    set_op(0, ALU_ADD, 32'd3, 32'd4);
    step(4'b0010, 4'b1111);
    chk("bp_grant", 32'(last_ready), 32'h2);
    for (int k = 0; k < 3; k++) begin
      step(4'b0001, 4'b1101);
      chk("bp_ready", 32'(last_ready), 32'd0);
      chk("bp_result", bus.rsp_result, 32'd0);
      chk("bp_zero", 32'(bus.rsp_zero), 32'd1);
    end
    step(4'b0001, 4'b0010);
    chk("drain_accept_ready", 32'(last_ready), 32'h1);
    chk("drain_accept_valid", 32'(bus.rsp_valid), 32'h1);
    chk("drain_accept_result", bus.rsp_result, 32'd7);

    // Arithmetic corner cases through req2.
    for (int i = 0; i < 5; i++) begin
      set_op(2, ac[i], aa[i], ab[i]);
      step(4'b0100, 4'b1111);
      chk("arith_result", bus.rsp_result, ae[i]);
      chk("arith_zero", 32'(bus.rsp_zero), (ae[i] == 32'd0) ? 32'd1 : 32'd0);
    end

    // Wrap from pointer 3 with only req3 and req0 valid.
    step(4'b0100, 4'b1111);
    set_op(3, ALU_OR, 32'h1, 32'h2);
    set_op(0, ALU_AND, 32'hFF, 32'h0F);
    for (int k = 0; k < 3; k++) begin
      step(4'b1001, 4'b1111);
`ifdef ALU_ARB_RR_EN
      exp_g = (k % 2 == 0) ? 4'b1000 : 4'b0001;
`else
      exp_g = 4'b0001;
`endif
      chk("wrap_grant", 32'(last_ready), 32'(exp_g));
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      logic [3:0] rv;
      logic [3:0] rr;
      for (int i = 0; i < N; i++)
        set_op(i, alu_t'(4'($urandom_range(0, 9))), rand_op(), rand_op());
      rv = 4'($urandom);
      rr = 4'($urandom) | ((c % 3 == 0) ? 4'b0000 : 4'b1111);
      step(rv, rr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Shares one instance of the core `alu` between up to four requesters, such as the execute stage, branch-target adder and CSR/address-generation logic. It uses valid/ready handshakes on both the request and response sides. Grants go round-robin, or fixed-priority when the round-robin feature is compiled out. Each granted operation is evaluated in the grant cycle and its result is held in a one-entry response register until the owning requester takes it.

## Interface
- `NREQ`, default 2: number of requesters; legal range 2..4.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `req_valid` input, [NREQ]: requester i presents an operation.
- `req_ready` output, [NREQ]: requester i's operation is accepted this cycle.
- `req_ctrl` input, alu_t [NREQ]: operation select per requester.
- `req_op1` input, [NREQ][32]: first operand per requester.
- `req_op2` input, [NREQ][32]: second operand per requester.
- `rsp_valid` output, [NREQ]: held result belongs to requester i; at most one bit set.
- `rsp_ready` input, [NREQ]: requester i takes the result.
- `rsp_result` output, 32 bits: held ALU result, shared by all requesters.
- `rsp_zero` output, 1 bit: held zero flag, set when the held result is 0.

## Operation
- The response register has two states:
  - EMPTY: no result held.
  - FULL: holds `rsp_result`, `rsp_zero` and owner index `own`.
- `can_accept` = (state == EMPTY) or (state == FULL and `rsp_ready[own]`).
- Grant selection:
  - Among asserted `req_valid` bits, pick one with the round-robin pointer `ptr` (scan from `ptr` upward, wrap NREQ-1 to 0).
  - `req_ready[g]` = `can_accept` and granted; all other `req_ready` bits are 0.
  - `req_ready` is combinational from `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- Accept edge (any grant g):
  - Mux requester g's ctrl/op1/op2 into the `alu`.
  - Register the result and zero flag; set `own` = g; state goes to FULL.
  - `ptr` = (g+1) mod NREQ.
- Drain without accept: `rsp_valid[own]` and `rsp_ready[own]` both high, no grant. State goes to EMPTY and the register contents are left unchanged.
- Drain and accept in the same cycle is legal and gives back-to-back throughput of one op per cycle.
- `rsp_ready` bits of non-owners are ignored.
- While FULL without drain, all register contents, `own` and `ptr` hold.
- `req_valid` may drop without acceptance; nothing is recorded.
- ALU arithmetic follows `alu` exactly:
  - 32-bit wrap-around on ADD and SUB.
  - Shift amount is op2[4:0].
  - SLT is signed; SLTU is unsigned; both produce 0 or 1.
  - Only defined `alu_t` encodings may be driven. Undefined encodings give an unspecified result.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - state EMPTY, `ptr` 0, `own` 0.
  - `rsp_valid` all 0, `rsp_result` 0x0000_0000, `rsp_zero` 0.
  - `req_ready` forced all 0 while `rst_n` is low.
- Reset mid-operation discards any held result; no response is produced for it.
- Latency: accept on edge N gives `rsp_valid` high from after edge N, i.e. in cycle N+1.
- Throughput: 1 op/cycle while the owner keeps `rsp_ready` high.
- Back-pressure: while FULL and not drained, `req_ready` is all 0.
- Round-robin fairness: with all requesters continuously valid and no back-pressure, each requester is granted once every NREQ cycles.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration as above.
- `ALU_ARB_RR_EN` undefined:
  - Fixed priority; the lowest asserted index wins.
  - `ptr` is not implemented and grant logic ignores it.
  - Higher-index requesters may starve; this is by design.

## Structure
- Shared package `riscv_types` already provides `alu_t`.
- Add to `riscv_types`:
  - `ALU_ARB_MAX_REQ` = 4.
  - Enum `arb_state_t` {ARB_EMPTY, ARB_FULL}.
- One sub-module: the existing `alu`, instantiated once.
- Grant logic, operand mux and response register are inline.

## Test plan
- Reset mid-hold: FULL with result 12; drop `rst_n` low for 1 cycle → immediately `rsp_valid`=0, `rsp_result`=0, `rsp_zero`=0, `req_ready`=0. After release, `req_ready[0]` rises with `req_valid[0]`.
- Single op: req0 ADD 5+7 accepted at edge N → cycle N+1 `rsp_valid[0]`=1, `rsp_result`=12, `rsp_zero`=0.
- Contention: NREQ=2, both valid every cycle, `rsp_ready`=1. With `ALU_ARB_RR_EN`, grants are 0,1,0,1. Without it, grants are 0,0,0,0 and `req_ready[1]` never rises.
- Back-pressure and same-cycle drain/accept: req1 SUB 9-9 accepted, `rsp_ready[1]`=0 for 3 cycles → `rsp_result`=0, `rsp_zero`=1 held, `req_ready` all 0 while req0 waits. In the cycle `rsp_ready[1]` rises, req0 is accepted; next cycle `rsp_valid[0]`=1.
- Arithmetic edges:
  - SRA 0x8000_0000 by 4 → 0xF800_0000.
  - SLL 1 with op2=0x21 → 2.
  - SLTU 1 vs 0xFFFF_FFFF → 1.
  - SLT 1 vs 0xFFFF_FFFF → 0.
  - ADD 0xFFFF_FFFF+1 → 0, `rsp_zero`=1.
- Round-robin wrap: NREQ=4, only req3 and req0 valid, `ptr`=3 → grant 3, then 0, then 3.
